skin_ellipse_classify: RTL and testbench

//  Final stage of the skin-tone datapath. It consumes the nonlinearly transformed

---
 rtl/skin_ellipse_classify.sv | 91 +++++++++
 tb/tb_skin_ellipse_classify.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/skin_ellipse_classify.sv
// skin_ellipse_classify: 4-stage rotated-ellipse skin classifier with a per-frame skin-pixel counter.
module skin_ellipse_classify #(
    parameter int CX    = 109,
    parameter int CY    = 152,
    parameter int COS_Q = -210,
    parameter int SIN_Q = 147,
    parameter int ECX   = 2,
    parameter int ECY   = 2,
    parameter int A2    = 645,
    parameter int B2    = 197,
    parameter int CNT_W = 20
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [7:0]       in_cb,
    input  logic [7:0]       in_cr,
    input  logic             in_sof,
    input  logic             in_eof,
    output logic             out_valid,
    output logic             out_skin,
    output logic             out_sof,
    output logic             out_eof,
    output logic [CNT_W-1:0] frame_skin_count,
    output logic             frame_done
);
    logic v1, v2, v3, sof1, sof2, sof3, eof1, eof2, eof3;
    logic signed [9:0] dcb, dcr;
    logic signed [19:0] sx, sy;
    logic signed [11:0] x, y;
    logic signed [23:0] dx, dy;
    logic [23:0] sqx, sqy;
    logic [35:0] e;
    logic [CNT_W-1:0] acc, acc_n;
    logic in_frame, open, close;

    always_comb begin
        sx = 20'(COS_Q * dcb + SIN_Q * dcr);
        sy = 20'(COS_Q * dcr - SIN_Q * dcb);
        dx = 24'(x) - 24'(ECX);
        dy = 24'(y) - 24'(ECY);
        e = 36'(sqx) * 36'(B2) + 36'(sqy) * 36'(A2);
        open = out_sof | (out_valid & in_frame);
        close = out_eof & (in_frame | out_sof);
        acc_n = out_sof ? CNT_W'(out_skin) : &acc ? acc : acc + CNT_W'(out_skin);
    end

    // Payload needs no reset; the valid chain qualifies it.
    always_ff @(posedge clk) begin
        dcb <= {2'b0, in_cb} - 10'(CX);
        dcr <= {2'b0, in_cr} - 10'(CY);
        sof1 <= in_sof;
        eof1 <= in_eof;
        x <= sx[19:8];
        y <= sy[19:8];
        sof2 <= sof1;
        eof2 <= eof1;
        sqx <= 24'(dx * dx);
        sqy <= 24'(dy * dy);
        sof3 <= sof2;
        eof3 <= eof2;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            {v1, v2, v3, out_valid, out_skin, out_sof, out_eof} <= '0;
        end else begin
            v1 <= in_valid;
            v2 <= v1;
            v3 <= v2;
            out_valid <= v3;
            out_skin <= v3 & (e <= 36'(A2 * B2));
            out_sof <= v3 & sof3;
            out_eof <= v3 & eof3;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc <= '0;
            in_frame <= 1'b0;
            frame_skin_count <= '0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= close;
            if (open) acc <= acc_n;
            if (close) frame_skin_count <= acc_n;
            in_frame <= close ? 1'b0 : (out_sof | in_frame);
        end
    end
endmodule

// File: tb/tb_skin_ellipse_classify.sv
// tb_skin_ellipse_classify: vector table, full chroma sweep and random frames against an integer ellipse model.
module tb_skin_ellipse_classify;
    localparam int N = 131072;

    logic clk = 1'b0, rst = 1'b1, in_valid = 1'b0, in_sof = 1'b0, in_eof = 1'b0;
    logic [7:0] in_cb = '0, in_cr = '0;
    logic ov, os, osf, oef, fd, ov4, os4, osf4, oef4, fd4;
    logic [19:0] fc;
    logic [3:0] fc4;

    typedef struct packed {bit v; bit s; bit e; bit r; bit [7:0] cb; bit [7:0] cr;} rec_t;
    rec_t hist [N];

    typedef struct {int cb; int cr; bit sof; bit eof; bit skin;} vec_t;
    vec_t tbl [6];

    int checks = 0, failures = 0, cyc = 0, done_cnt = 0, done4_cnt = 0;

    skin_ellipse_classify dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_cb(in_cb), .in_cr(in_cr),
        .in_sof(in_sof), .in_eof(in_eof), .out_valid(ov), .out_skin(os), .out_sof(osf),
        .out_eof(oef), .frame_skin_count(fc), .frame_done(fd)
    );

    skin_ellipse_classify #(.CNT_W(4)) dut4 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_cb(in_cb), .in_cr(in_cr),
        .in_sof(in_sof), .in_eof(in_eof), .out_valid(ov4), .out_skin(os4), .out_sof(osf4),
        .out_eof(oef4), .frame_skin_count(fc4), .frame_done(fd4)
    );

    always #5 clk = ~clk;

    function automatic int fdiv256(input int n);
        return n >= 0 ? n / 256 : -((-n + 255) / 256);
    endfunction

    function automatic bit model(input int cb, input int cr);
        int dcb, dcr;
        longint dx, dy;
        dcb = cb - 109;
        dcr = cr - 152;
        dx = longint'(fdiv256(-210 * dcb + 147 * dcr)) - 2;
        dy = longint'(fdiv256(-210 * dcr - 147 * dcb)) - 2;
        return dx * dx * 197 + dy * dy * 645 <= 645 * 197;
    endfunction

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        hist[cyc % N] <= '{v: in_valid, s: in_sof, e: in_eof, r: rst, cb: in_cb, cr: in_cr};
        cyc <= cyc + 1;
    end

    // Output at this point must equal the input sampled four edges back, unless a reset intervened.
    always @(negedge clk) begin
        rec_t h;
        bit lost, ev;
        if (cyc >= 4) begin
            h = hist[(cyc - 4) % N];
            lost = hist[(cyc - 1) % N].r | hist[(cyc - 2) % N].r | hist[(cyc - 3) % N].r | hist[(cyc - 4) % N].r;
            ev = h.v & !lost;
            chk("pipe", {ov, os, osf, oef}, {ev, ev & model(h.cb, h.cr), ev & h.s, ev & h.e});
            chk("pipe4", {ov4, os4, osf4, oef4}, {ev, ev & model(h.cb, h.cr), ev & h.s, ev & h.e});
            if (hist[(cyc - 1) % N].r) begin
                chk("rst_frame", {fd, fc}, 0);
                chk("rst_frame4", {fd4, fc4}, 0);
            end
            done_cnt += int'(fd);
            done4_cnt += int'(fd4);
        end
    end

    task automatic px(input int cb, input int cr, input bit s, input bit e);
        in_cb = 8'(cb);
        in_cr = 8'(cr);
        in_sof = s;
        in_eof = e;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        in_sof = 1'b0;
        in_eof = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_frame(input bit [63:0] pat, input int n, input bit bub, input bit do_eof);
        for (int i = 0; i < n; i++) begin
            px(pat[i] ? 109 : 200, pat[i] ? 152 : 60, i == 0, do_eof && i == n - 1);
            if (bub && i % 2 == 1) idle(1 + i % 3);
        end
    endtask

    initial begin
        int d0, d4, lat, n, exp, cb, cr;
        tbl[0] = '{109, 152, 0, 0, 1};
        tbl[1] = '{200, 60, 0, 0, 0};
        tbl[2] = '{110, 152, 1, 0, 1};
        tbl[3] = '{0, 0, 0, 1, 0};
        tbl[4] = '{255, 255, 1, 1, 0};
        tbl[5] = '{109, 152, 0, 1, 1};
        repeat (2) begin
            @(posedge clk);
            @(negedge clk);
            chk("reset_out", {ov, os, osf, oef, fd, fc}, 0);
            chk("reset_out4", {ov4, os4, osf4, oef4, fd4, fc4}, 0);
        end
        rst = 1'b0;
        idle(2);

        foreach (tbl[k]) begin
            px(tbl[k].cb, tbl[k].cr, tbl[k].sof, tbl[k].eof);
            lat = 0;
            while (!ov && lat < 8) begin
                @(negedge clk);
                lat++;
            end
            chk("latency", lat, 3);
            chk("tbl_out", {ov, os, osf, oef}, {1'b1, tbl[k].skin, tbl[k].sof, tbl[k].eof});
            idle(1);
        end
        idle(6);
        chk("tbl_done", done_cnt, 2);
        chk("tbl_count", fc, 0);

        d0 = done_cnt;
        for (int a = 0; a < 256; a++)
            for (int b = 0; b < 256; b++) px(a, b, 0, 0);
        idle(8);
        chk("sweep_done", done_cnt - d0, 0);

        d0 = done_cnt;
        send_frame(64'b1010101101, 10, 1, 1);
        idle(8);
        chk("f10_done", done_cnt - d0, 1);
        chk("f10_count", fc, 6);
        idle(20);
        chk("f10_stable", fc, 6);
        chk("f10_once", done_cnt - d0, 1);

        d0 = done_cnt;
        px(109, 152, 1, 1);
        idle(8);
        chk("single_done", done_cnt - d0, 1);
        chk("single_count", fc, 1);
        d0 = done_cnt;
        send_frame(64'b111, 3, 0, 0);
        send_frame(64'b101, 3, 1, 1);
        idle(8);
        chk("discard_done", done_cnt - d0, 1);
        chk("discard_count", fc, 2);
        d0 = done_cnt;
        px(109, 152, 0, 1);
        px(109, 152, 0, 0);
        idle(8);
        chk("stray_eof_done", done_cnt - d0, 0);
        chk("stray_eof_count", fc, 2);

        d0 = done_cnt;
        d4 = done4_cnt;
        send_frame(64'hFFFFF, 20, 1, 1);
        idle(8);
        chk("sat_count20", fc, 20);
        chk("sat_count4", fc4, 15);
        chk("sat_done4", done4_cnt - d4, 1);

        d0 = done_cnt;
        send_frame(64'b1111, 4, 0, 0);
        rst = 1'b1;
        px(109, 152, 0, 1);
        rst = 1'b0;
        idle(8);
        chk("rst_mid_done", done_cnt - d0, 0);
        chk("rst_mid_count", fc, 0);
        send_frame(64'b011, 3, 0, 1);
        idle(8);
        chk("after_rst_done", done_cnt - d0, 1);
        chk("after_rst_count", fc, 2);
        chk("after_rst_count4", fc4, 2);

        repeat (1500) begin
            in_valid = ($urandom % 4) != 0;
            in_cb = 8'($urandom);
            in_cr = 8'($urandom);
            in_sof = ($urandom % 16) == 0;
            in_eof = ($urandom % 16) == 0;
            @(negedge clk);
        end
        in_valid = 1'b0;
        in_sof = 1'b0;
        in_eof = 1'b0;
        idle(8);

        repeat (20) begin
            n = $urandom_range(1, 40);
            exp = 0;
            d0 = done_cnt;
            d4 = done4_cnt;
            for (int i = 0; i < n; i++) begin
                cb = 89 + $urandom_range(0, 40);
                cr = 132 + $urandom_range(0, 40);
                exp += int'(model(cb, cr));
                px(cb, cr, i == 0, i == n - 1);
                if ($urandom % 3 == 0) idle($urandom_range(1, 3));
            end
            idle(8);
            chk("rnd_done", done_cnt - d0, 1);
            chk("rnd_done4", done4_cnt - d4, 1);
            chk("rnd_count", fc, exp);
            chk("rnd_count4", fc4, exp > 15 ? 15 : exp);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
